// File: rtl/display_pkg.sv
// display_pkg: scan FSM states and width helper shared by the display scan blocks
package display_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, BLANK, LATCH} state_t;
  function automatic int bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/display_valid_delay.sv
// display_valid_delay: LATENCY-deep valid pipeline aligning shift_en with encoder rgb
module display_valid_delay #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [LATENCY-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= LATENCY'({sr, din});
  assign dout = sr[LATENCY-1];
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: HUB75 scan sequencer driving frame-buffer reads, PWM cycle and panel strobes
module display_scan_controller
  import display_pkg::*;
#(
  parameter int COLUMNS    = 64,
  parameter int ROWS       = 16,
  parameter int CYCLEWIDTH = 8,
  parameter int LATENCY    = 2,
  localparam int AW = bits(ROWS * COLUMNS),
  localparam int RW = bits(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [AW-1:0]         fb_addr,
  output logic [CYCLEWIDTH-1:0] cycle,
  output logic                  shift_en,
  output logic                  latch,
  output logic                  oe_n,
  output logic [RW-1:0]         row_addr,
  output logic                  frame_done
);
  localparam int CLW = bits(COLUMNS);
  localparam int DW  = bits(LATENCY);
  localparam logic [CLW-1:0]        COL_LAST = CLW'(COLUMNS - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0]         DRN_LAST = DW'(LATENCY - 1);
  localparam logic [CYCLEWIDTH-1:0] CYC_LAST = '1;
  state_t                  state, state_nx;
  logic [CLW-1:0]          col;
  logic [RW-1:0]           row;
  logic [CYCLEWIDTH-1:0]   cyc;
  logic [DW-1:0]           drn;
  logic                    lit;
  logic                    cyc_wrap, frame_wrap;
  assign cyc_wrap   = cyc == CYC_LAST;
  assign frame_wrap = cyc_wrap && row == ROW_LAST;
  assign fb_addr    = AW'(row) * AW'(COLUMNS) + AW'(col);
  assign cycle      = cyc;
  always_comb begin
    state_nx   = state == IDLE  ? (enable ? SHIFT : IDLE)
               : state == SHIFT ? (col == COL_LAST ? DRAIN : SHIFT)
               : state == DRAIN ? (drn == DRN_LAST ? BLANK : DRAIN)
               : state == BLANK ? LATCH
               : (frame_wrap && !enable ? IDLE : SHIFT);
    latch      = state == LATCH;
    frame_done = latch && frame_wrap;
    oe_n       = !(lit && (state == SHIFT || state == DRAIN));
  end
  // row_addr is loaded entering LATCH so it only moves while the panel is blanked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      cyc      <= '0;
      drn      <= '0;
      lit      <= 1'b0;
      row_addr <= '0;
    end else begin
      state <= state_nx;
      col   <= state == SHIFT ? (col == COL_LAST ? '0 : col + 1'b1) : col;
      drn   <= state == DRAIN ? (drn == DRN_LAST ? '0 : drn + 1'b1) : drn;
      lit   <= state == LATCH ? state_nx != IDLE : state == IDLE ? 1'b0 : lit;
      if (state == BLANK) row_addr <= row;
      if (state == LATCH) begin
        cyc <= cyc_wrap ? '0 : cyc + 1'b1;
        if (cyc_wrap) row <= row == ROW_LAST ? '0 : row + 1'b1;
      end
    end
  display_valid_delay #(.LATENCY(LATENCY)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (state == SHIFT),
    .dout (shift_en)
  );
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: two panel geometries against a frame-timeline reference model
module tb_display_scan_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  bit   done = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {int t; bit la; int cyc; bit fd; int row;} ev_t;

  always #5 clk = ~clk;

  function automatic void check(input int g, input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL [cfg%0d t=%0t] %s: got %0d, expected %0d", g, $time, name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int COLS = g ? 5 : 4;
    localparam int RWS  = g ? 3 : 2;
    localparam int CWD  = 2;
    localparam int LAT  = 2;
    localparam int P    = COLS + LAT + 2;
    localparam int C    = 1 << CWD;
    localparam int NP   = RWS * C;
    localparam int FR   = NP * P;

    logic [$clog2(RWS*COLS)-1:0] fb_addr;
    logic [CWD-1:0]              cycle;
    logic                        shift_en, latch, oe_n, frame_done;
    logic [$clog2(RWS)-1:0]      row_addr;

    display_scan_controller #(.COLUMNS(COLS), .ROWS(RWS), .CYCLEWIDTH(CWD), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .fb_addr   (fb_addr),
      .cycle     (cycle),
      .shift_en  (shift_en),
      .latch     (latch),
      .oe_n      (oe_n),
      .row_addr  (row_addr),
      .frame_done(frame_done)
    );

    ev_t q[$];
    bit  run, lit;
    int  k, tc, rowa, exp_oe, exp_addr, exp_rowa;

    // k is the clock index within the running frame; everything else follows from it
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run = 0; lit = 0; k = 0; rowa = 0;
        exp_oe = 1; exp_addr = 0; exp_rowa = 0;
        q.delete();
      end else begin
        int ph, p, row, cy;
        tc++;
        if (run) begin
          if (k % P == P - 1) begin
            if (k == FR - 1 && !enable) begin run = 0; lit = 0; end
            else begin lit = 1; k = (k == FR - 1) ? 0 : k + 1; end
          end else k++;
        end else if (enable) begin
          run = 1; k = 0;
        end
        if (run) begin
          ph = k % P; p = k / P; row = p / C; cy = p % C;
          exp_addr = ph < COLS ? row * COLS + ph : -1;
          exp_oe   = !(lit && ph < COLS + LAT);
          if (ph == P - 1) rowa = row;
          if (ph >= LAT && ph < LAT + COLS) q.push_back('{tc, 1'b0, cy, 1'b0, row});
          if (ph == P - 1) q.push_back('{tc, 1'b1, cy, p == NP - 1, row});
        end else begin
          exp_addr = 0; exp_oe = 1;
        end
        exp_rowa = rowa;
      end
    end

    int  prev_row, prev_cyc;
    bit  prev_se;
    always @(posedge clk) begin
      #1;
      if (rst_n) begin
        ev_t r;
        if (shift_en || latch) begin
          check(g, "event_pending", q.size() > 0, 1);
          if (q.size() > 0) begin
            r = q.pop_front();
            check(g, "event_time", tc, r.t);
            check(g, "event_is_latch", latch, r.la);
            if (r.la) begin
              check(g, "frame_done", frame_done, r.fd);
              check(g, "latch_row_addr", row_addr, r.row);
            end else check(g, "shift_cycle", cycle, r.cyc);
          end
        end
        while (q.size() > 0 && q[0].t < tc) begin
          check(g, "missed_event_time", tc, q[0].t);
          void'(q.pop_front());
        end
        if (!latch) check(g, "frame_done_quiet", frame_done, 0);
        check(g, "oe_n", oe_n, exp_oe);
        if (exp_addr >= 0) check(g, "fb_addr", fb_addr, exp_addr);
        check(g, "row_addr", row_addr, exp_rowa);
        if (row_addr != prev_row) check(g, "row_change_oe_n", oe_n, 1);
        if (shift_en && prev_se) check(g, "cycle_stable", cycle, prev_cyc);
        prev_row = row_addr; prev_se = shift_en; prev_cyc = cycle;
      end else begin
        prev_row = 0; prev_se = 0;
      end
    end

    always @(negedge rst_n) begin
      #1;
      check(g, "rst_fb_addr", fb_addr, 0);
      check(g, "rst_cycle", cycle, 0);
      check(g, "rst_shift_en", shift_en, 0);
      check(g, "rst_latch", latch, 0);
      check(g, "rst_oe_n", oe_n, 1);
      check(g, "rst_row_addr", row_addr, 0);
      check(g, "rst_frame_done", frame_done, 0);
    end

    initial begin
      wait (done);
      check(g, "leftover_events", q.size(), 0);
    end
  end

  initial begin
    rst_n = 1'b1;
    enable = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // one frame with enable dropped early: must complete, then idle
    enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    // re-assert during the 4x2 frame_done clock: back-to-back frames
    enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (44) @(negedge clk);
    enable = 1'b1;
    repeat (36) @(negedge clk);
    enable = 1'b0;
    repeat (300) @(negedge clk);
    // reset in the middle of the first SHIFT, released with enable high
    enable = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        #($urandom_range(1, 3)) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end
    enable = 1'b0;
    repeat (400) @(negedge clk);
    done = 1'b1;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
